// File: rtl/speck_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : speck_decrypt
// Description : Iterative SPECK128/128 decryption core. Captures a
//               ciphertext/key pair, expands the key forward into a round-key
//               buffer, then applies the inverse round backwards through it.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef NR_ROUNDS
`define NR_ROUNDS 32
`endif

module speck_decrypt #(
  parameter int NR_ROUNDS = `NR_ROUNDS,
  parameter int WORD      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2*WORD-1:0] ciphertext,
  input  logic [2*WORD-1:0] key,
  output logic [2*WORD-1:0] plaintext,
  output logic              active,
  output logic              ready
);

  localparam int RCW = (NR_ROUNDS > 1) ? $clog2(NR_ROUNDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXPAND  = 2'd1,
    S_DECRYPT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WORD-1:0]    r_x, r_y, r_k, r_l;
  logic [RCW-1:0]     r_rc;
  logic [WORD-1:0]    r_buf [NR_ROUNDS];

  logic               w_accept;
  logic               w_last_exp;
  logic               w_last_dec;
  logic [RCW-1:0]     w_rc_inc;
  logic [WORD-1:0]    w_l_nxt, w_k_nxt;
  logic [WORD-1:0]    w_rk;
  logic [WORD-1:0]    w_x_dec, w_y_dec;

  // Constant rotations (alpha = 8, beta = 3)
  function automatic logic [WORD-1:0] ror8(input logic [WORD-1:0] v);
    return {v[7:0], v[WORD-1:8]};
  endfunction

  function automatic logic [WORD-1:0] rol8(input logic [WORD-1:0] v);
    return {v[WORD-9:0], v[WORD-1:WORD-8]};
  endfunction

  function automatic logic [WORD-1:0] ror3(input logic [WORD-1:0] v);
    return {v[2:0], v[WORD-1:3]};
  endfunction

  function automatic logic [WORD-1:0] rol3(input logic [WORD-1:0] v);
    return {v[WORD-4:0], v[WORD-1:WORD-3]};
  endfunction

  // Key-schedule step, inverse round and FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = (r_state == S_IDLE) && start;
    w_last_exp  = (r_state == S_EXPAND) && (r_rc == RCW'(NR_ROUNDS - 2));
    w_last_dec  = (r_state == S_DECRYPT) && (r_rc == '0);
    w_rc_inc    = r_rc + RCW'(1);
    // rc doubles as the round counter mixed into the key schedule
    w_l_nxt     = (r_k + ror8(r_l)) ^ WORD'(r_rc);
    w_k_nxt     = rol3(r_k) ^ w_l_nxt;
    w_rk        = r_buf[r_rc];
    w_y_dec     = ror3(r_x ^ r_y);
    w_x_dec     = rol8((r_x ^ w_rk) - w_y_dec);
    case (r_state)
      S_IDLE:    if (w_accept)   w_state_nxt = S_EXPAND;
      S_EXPAND:  if (w_last_exp) w_state_nxt = S_DECRYPT;
      S_DECRYPT: if (w_last_dec) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath, round counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_k       <= '0;
      r_l       <= '0;
      r_rc      <= '0;
      plaintext <= '0;
      active    <= 1'b0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x    <= ciphertext[2*WORD-1:WORD];
            r_y    <= ciphertext[WORD-1:0];
            r_k    <= key[2*WORD-1:WORD];
            r_l    <= key[WORD-1:0];
            r_rc   <= '0;
            active <= 1'b1;
          end
        end
        S_EXPAND: begin
          r_l  <= w_l_nxt;
          r_k  <= w_k_nxt;
          // Final expand step lands rc on NR_ROUNDS-1, the first decrypt key
          r_rc <= w_rc_inc;
        end
        S_DECRYPT: begin
          r_x <= w_x_dec;
          r_y <= w_y_dec;
          if (w_last_dec) begin
            plaintext <= {w_x_dec, w_y_dec};
            ready     <= 1'b1;
            active    <= 1'b0;
          end else begin
            r_rc <= r_rc - RCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Round-key buffer; contents are don't-care until written by a job
  always_ff @(posedge clk) begin
    if (w_accept)
      r_buf[0] <= key[2*WORD-1:WORD];
    else if (r_state == S_EXPAND)
      r_buf[w_rc_inc] <= w_k_nxt;
  end

endmodule

`default_nettype wire

// File: doc/speck_decrypt.md
# speck_decrypt

Iterative SPECK128/128 decryption core: the inverse of the team's encryption datapath, sharing its word layout and key format. On `start` it captures a ciphertext/key pair, expands the key forward into an internal round-key buffer, then runs the inverse round function backwards through the buffer. It sits beside the encryption block, and the two are used as a loopback pair.

## Interface
- `NR_ROUNDS`, default `` `NR_ROUNDS `` (32): number of rounds. It must match the encryptor.
- `WORD`, default 64: word width n. The 128-bit block is the x‖y pair of words.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request decryption; sampled only in IDLE.
- `ciphertext`  in  128  x = [127:64], y = [63:0]; captured on the accepting edge.
- `key`  in  128  k0 = [127:64], l0 = [63:0]; captured on the accepting edge.
- `plaintext`  out  128  result register; holds its value until the next completion.
- `active`  out  1  high from the accepting edge until completion.
- `ready`  out  1  one-cycle pulse when `plaintext` is valid.

## Operation
- States: IDLE → EXPAND → DECRYPT → IDLE.
- Arithmetic:
  - All 64-bit operations are mod 2^64.
  - ROR and ROL are rotations by a constant amount.
  - α = 8, β = 3.
- IDLE, when `start` = 1:
  - Latch x, y, k0, l0 into registers.
  - Write k0 to buffer entry 0.
  - Set `rc` = 0 and `active` = 1, then go to EXPAND.
- EXPAND (each cycle):
  - l ← (k + ROR(l,8)) ^ rc.
  - k ← ROL(k,3) ^ l_new.
  - Write k_new to buffer entry rc+1, then rc ← rc+1.
  - When rc+1 = NR_ROUNDS−1, set rc ← NR_ROUNDS−1 and go to DECRYPT.
- DECRYPT (each cycle, with K = buffer[rc]):
  - y ← ROR(x ^ y, 3).
  - x ← ROL((x ^ K) − y_new, 8).
  - When rc = 0:
    - `plaintext` ← {x_new, y_new}.
    - `ready` ← 1 and `active` ← 0.
    - Go to IDLE.
  - Otherwise rc ← rc − 1.
- Round-key buffer:
  - NR_ROUNDS × 64 register array.
  - Read index is `rc` (combinational read).
  - Contents are undefined after reset and never observable at the outputs.
- Inputs change freely after capture; the core uses only its latched copies.

## Timing
- Reset (rst_n = 0, asynchronous):
  - State = IDLE, `active` = 0, `ready` = 0, `plaintext` = 0, `rc` = 0.
  - Applies immediately, including mid-EXPAND or mid-DECRYPT.
  - The aborted job produces no `ready` and no `plaintext` update.
- Accept edge E0 is the edge on which IDLE samples `start` = 1.
  - EXPAND spans edges E1…E(NR_ROUNDS−1).
  - DECRYPT spans edges E(NR_ROUNDS)…E(2·NR_ROUNDS−1).
- Latency:
  - `ready` rises after E(2·NR_ROUNDS−1), which is E63 for 32 rounds.
  - `ready` falls after the next edge.
- `active` is high after E0 through E(2·NR_ROUNDS−2). It is low in the same cycle that `ready` is high.
- `start` outside IDLE is ignored; it is not queued.
- `start` held high continuously gives back-to-back jobs:
  - The cycle `ready` = 1 is an IDLE cycle, so the next job is accepted there.
  - Throughput is one block per 2·NR_ROUNDS cycles.
- `plaintext` changes only on the completion edge or on reset.

## Test plan
- Official vector:
  - Stimulus: key = 0706050403020100_0f0e0d0c0b0a0908, ciphertext = a65d985179783265_7860fedf5c570d18.
  - Required: `plaintext` = 6c61766975716520_7469206564616d20, with `ready` pulsing exactly 63 cycles after E0 for one cycle.
- Loopback:
  - Stimulus: 200 random key/plaintext pairs through the encryptor, then through this core.
  - Required: original plaintext recovered each time; `active`/`ready` timing exact.
- Start during busy:
  - Stimulus: pulse `start` with new inputs at E10 and at E40 of a job.
  - Required: ignored; result matches the first job only; a single `ready` pulse.
- Held `start`:
  - Stimulus: `start` = 1 for 3 jobs, with inputs changed in each `ready` cycle.
  - Required: `ready` at E63, E127, E191; each `plaintext` matches its own job.
- Reset mid-operation:
  - Stimulus: assert `rst_n` = 0 asynchronously during DECRYPT (E45), between clock edges.
  - Required: outputs go to 0 immediately with no `ready`. A fresh job after release completes normally at E63.
- Zero vector:
  - Stimulus: key = 0, ciphertext = encrypt(0, 0).
  - Required: `plaintext` = 0, confirming the `rc` XOR path and the mod-2^64 borrow handling.
